// File: rtl/data_buffer_arbiter.sv
// Arbitrates a single buffer port between an AHB and a USB requester, issuing
// guarded store/get beat strobes and ending each grant by completion or abort.
module data_buffer_arbiter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       ahb_req,
  input  logic       ahb_wr,
  input  logic [6:0] ahb_len,
  input  logic       usb_req,
  input  logic       usb_wr,
  input  logic [6:0] usb_len,
  input  logic [6:0] buffer_occupancy,
  input  logic       buf_ready,
  input  logic       clear,
  output logic       ahb_gnt,
  output logic       usb_gnt,
  output logic       buf_store,
  output logic       buf_get,
  output logic       ahb_done,
  output logic       usb_done,
  output logic       xfer_abort
);

  typedef enum logic [1:0] {
    IDLE,
    OWN_AHB,
    OWN_USB
  } state_t;

  localparam logic [6:0] MAX_LEN = 7'd64;

  state_t     state_q, state_d;
  logic [6:0] remaining_q, remaining_d;
  logic [3:0] stall_q, stall_d;
  logic       last_owner_q, last_owner_d;  // 1 = AHB owned last, 0 = USB

  logic       ahb_ok, usb_ok;
  logic       own_req, own_wr, guard_ok, owner_is_ahb;
  logic       gnt_a, gnt_u, store_c, get_c, done_a, done_u, abort_c;

  function automatic logic [6:0] clamp_len(input logic [6:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    stall_d      = stall_q;
    last_owner_d = last_owner_q;
    gnt_a        = 1'b0;
    gnt_u        = 1'b0;
    store_c      = 1'b0;
    get_c        = 1'b0;
    done_a       = 1'b0;
    done_u       = 1'b0;
    abort_c      = 1'b0;

    ahb_ok       = ahb_req && (ahb_len != 7'd0);
    usb_ok       = usb_req && (usb_len != 7'd0);
    owner_is_ahb = (state_q == OWN_AHB);
    own_req      = owner_is_ahb ? ahb_req : usb_req;
    own_wr       = owner_is_ahb ? ahb_wr : usb_wr;
    guard_ok     = own_wr ? (buffer_occupancy < MAX_LEN) : (buffer_occupancy != 7'd0);

    case (state_q)
      IDLE: begin
        // Zero-length requests are invisible; on a tie the previous owner yields.
        if (!clear) begin
          if (ahb_ok && (!usb_ok || !last_owner_q)) begin
            state_d     = OWN_AHB;
            remaining_d = clamp_len(ahb_len);
            stall_d     = 4'd0;
          end else if (usb_ok) begin
            state_d     = OWN_USB;
            remaining_d = clamp_len(usb_len);
            stall_d     = 4'd0;
          end
        end
      end
      OWN_AHB, OWN_USB: begin
        gnt_a = owner_is_ahb;
        gnt_u = !owner_is_ahb;
        // A dropped request counts as a clear; either outranks beats and timeout.
        if (clear || !own_req) begin
          abort_c      = 1'b1;
          state_d      = IDLE;
          stall_d      = 4'd0;
          last_owner_d = owner_is_ahb;
        end else if (buf_ready && guard_ok) begin
          store_c     = own_wr;
          get_c       = !own_wr;
          remaining_d = remaining_q - 7'd1;
          stall_d     = 4'd0;
          if (remaining_q == 7'd1) begin
            done_a       = owner_is_ahb;
            done_u       = !owner_is_ahb;
            state_d      = IDLE;
            last_owner_d = owner_is_ahb;
          end
        end else if (stall_q == 4'd15) begin
          abort_c      = 1'b1;
          state_d      = IDLE;
          stall_d      = 4'd0;
          last_owner_d = owner_is_ahb;
        end else begin
          stall_d = stall_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ahb_gnt    = n_rst && gnt_a;
    usb_gnt    = n_rst && gnt_u;
    buf_store  = n_rst && store_c;
    buf_get    = n_rst && get_c;
    ahb_done   = n_rst && done_a;
    usb_done   = n_rst && done_u;
    xfer_abort = n_rst && abort_c;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      remaining_q  <= 7'd0;
      stall_q      <= 4'd0;
      last_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      stall_q      <= stall_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_data_buffer_arbiter.sv
// Self-checking bench for data_buffer_arbiter: directed vector table, corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_data_buffer_arbiter;

  typedef struct {
    logic       n_rst;
    logic       ahb_req;
    logic       ahb_wr;
    logic [6:0] ahb_len;
    logic       usb_req;
    logic       usb_wr;
    logic [6:0] usb_len;
    logic [6:0] occ;
    logic       ready;
    logic       clr;
  } in_t;

  typedef struct {
    in_t        stim;
    logic [6:0] exp;  // {ahb_gnt, usb_gnt, store, get, ahb_done, usb_done, abort}
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst, ahb_req, ahb_wr, usb_req, usb_wr, buf_ready, clear;
  logic [6:0] ahb_len, usb_len, buffer_occupancy;
  logic       ahb_gnt, usb_gnt, buf_store, buf_get, ahb_done, usb_done, xfer_abort;

  int         checks   = 0;
  int         failures = 0;
  logic [6:0] obs;

  // Reference model: who owns the port, beats left, consecutive stalled cycles.
  int m_owner = 0;  // 0 none, 1 AHB, 2 USB
  int m_left  = 0;
  int m_stall = 0;
  int m_last  = 2;

  vec_t vecs[$];

  always #5 clk = ~clk;

  data_buffer_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .ahb_req(ahb_req), .ahb_wr(ahb_wr), .ahb_len(ahb_len),
    .usb_req(usb_req), .usb_wr(usb_wr), .usb_len(usb_len),
    .buffer_occupancy(buffer_occupancy), .buf_ready(buf_ready), .clear(clear),
    .ahb_gnt(ahb_gnt), .usb_gnt(usb_gnt), .buf_store(buf_store), .buf_get(buf_get),
    .ahb_done(ahb_done), .usb_done(usb_done), .xfer_abort(xfer_abort)
  );

  function automatic in_t mk(input logic rst, input logic areq, input logic awr, input int alen,
                             input logic ureq, input logic uwr, input int ulen,
                             input int occ, input logic rdy, input logic clr);
    in_t s;
    s.n_rst = rst; s.ahb_req = areq; s.ahb_wr = awr; s.ahb_len = 7'(alen);
    s.usb_req = ureq; s.usb_wr = uwr; s.usb_len = 7'(ulen);
    s.occ = 7'(occ); s.ready = rdy; s.clr = clr;
    return s;
  endfunction

  task automatic add_vec(input in_t s, input logic [6:0] e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // One cycle of the transfer rules, computed from the requester's point of view.
  function automatic void model_eval(input in_t s, output logic [6:0] e,
                                     output int n_owner, output int n_left,
                                     output int n_stall, output int n_last);
    int  pick, req_len;
    logic req, wr, can_beat;
    e = 7'd0; n_owner = m_owner; n_left = m_left; n_stall = m_stall; n_last = m_last;
    if (!s.n_rst) begin
      n_owner = 0; n_left = 0; n_stall = 0; n_last = 2;
      return;
    end
    if (m_owner == 0) begin
      pick = 0;
      if (!s.clr) begin
        if (s.ahb_req && s.ahb_len != 0 && s.usb_req && s.usb_len != 0) pick = (m_last == 1) ? 2 : 1;
        else if (s.ahb_req && s.ahb_len != 0) pick = 1;
        else if (s.usb_req && s.usb_len != 0) pick = 2;
      end
      if (pick != 0) begin
        req_len = (pick == 1) ? int'(s.ahb_len) : int'(s.usb_len);
        n_owner = pick;
        n_left  = (req_len > 64) ? 64 : req_len;
        n_stall = 0;
      end
      return;
    end
    e[6]     = (m_owner == 1);
    e[5]     = (m_owner == 2);
    req      = (m_owner == 1) ? s.ahb_req : s.usb_req;
    wr       = (m_owner == 1) ? s.ahb_wr : s.usb_wr;
    can_beat = s.ready && (wr ? (int'(s.occ) < 64) : (int'(s.occ) > 0));
    if (s.clr || !req) begin
      e[0] = 1'b1; n_owner = 0; n_last = m_owner;
    end else if (can_beat) begin
      if (wr) e[4] = 1'b1; else e[3] = 1'b1;
      n_left  = m_left - 1;
      n_stall = 0;
      if (n_left == 0) begin
        if (m_owner == 1) e[2] = 1'b1; else e[1] = 1'b1;
        n_owner = 0; n_last = m_owner;
      end
    end else if (m_stall + 1 == 16) begin
      e[0] = 1'b1; n_owner = 0; n_last = m_owner;
    end else begin
      n_stall = m_stall + 1;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input in_t s);
    logic [6:0] e;
    int no, nl, ns, nla;
    @(negedge clk);
    n_rst = s.n_rst; ahb_req = s.ahb_req; ahb_wr = s.ahb_wr; ahb_len = s.ahb_len;
    usb_req = s.usb_req; usb_wr = s.usb_wr; usb_len = s.usb_len;
    buffer_occupancy = s.occ; buf_ready = s.ready; clear = s.clr;
    #2;
    obs = {ahb_gnt, usb_gnt, buf_store, buf_get, ahb_done, usb_done, xfer_abort};
    model_eval(s, e, no, nl, ns, nla);
    checkOutput("model", obs, e);
    @(posedge clk);
    m_owner = no; m_left = nl; m_stall = ns; m_last = nla;
  endtask

  initial begin
    int stores, dones, aborts, abort_at, gnt_cycles;
    int len_pick[10];
    in_t s;
    logic a_req, u_req;

    len_pick = '{0, 1, 2, 3, 5, 64, 65, 100, 127, 4};
    n_rst = 1'b0; ahb_req = 1'b0; ahb_wr = 1'b0; ahb_len = 7'd0;
    usb_req = 1'b0; usb_wr = 1'b0; usb_len = 7'd0;
    buffer_occupancy = 7'd0; buf_ready = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, tie-break, clear on last beat, clear in IDLE, zero-length request.
    add_vec(mk(0, 0,0,0, 0,0,0, 0,0,0), 7'b0000000);
    add_vec(mk(1, 1,0,2, 1,0,3, 10,1,0), 7'b0000000);
    add_vec(mk(1, 1,0,2, 1,0,3, 10,1,0), 7'b1001000);
    add_vec(mk(1, 1,0,2, 1,0,3, 10,1,0), 7'b1001100);
    add_vec(mk(1, 1,0,2, 1,0,3, 10,1,0), 7'b0000000);
    add_vec(mk(1, 1,0,2, 1,0,3, 10,1,0), 7'b0101000);
    add_vec(mk(1, 1,0,2, 1,0,3, 10,1,0), 7'b0101000);
    add_vec(mk(1, 1,0,2, 1,0,3, 10,1,0), 7'b0101010);
    add_vec(mk(1, 0,0,2, 0,0,3, 10,1,0), 7'b0000000);
    add_vec(mk(1, 0,0,0, 1,0,1, 10,1,0), 7'b0000000);
    add_vec(mk(1, 0,0,0, 1,0,1, 10,1,1), 7'b0100001);
    add_vec(mk(1, 0,0,0, 0,0,1, 10,1,0), 7'b0000000);
    add_vec(mk(1, 0,0,0, 1,0,1, 10,1,1), 7'b0000000);
    add_vec(mk(1, 0,0,0, 1,0,1, 10,1,0), 7'b0000000);
    add_vec(mk(1, 0,0,0, 1,0,1, 10,1,0), 7'b0101010);
    add_vec(mk(1, 0,0,0, 0,0,1, 10,1,0), 7'b0000000);
    add_vec(mk(1, 1,0,0, 0,0,0, 10,1,0), 7'b0000000);
    add_vec(mk(1, 1,0,0, 0,0,0, 10,1,0), 7'b0000000);
    add_vec(mk(1, 0,0,0, 0,0,0, 10,1,0), 7'b0000000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Full guard: no store while occupancy sits at 64, then four beats.
    applyStimulus(mk(1, 0,0,0, 1,1,4, 64,1,0));
    stores = 0; dones = 0; aborts = 0; gnt_cycles = 0;
    for (int c = 0; c < 9; c++) begin
      applyStimulus(mk(1, 0,0,0, 1,1,4, (c < 5) ? 64 : 60, 1, 0));
      if (c < 5 && obs[4]) checkOutput("full_store_at_64", {6'd0, obs[4]}, 7'd0);
      stores += obs[4]; dones += obs[1]; aborts += obs[0]; gnt_cycles += obs[5];
    end
    checkOutput("full_gnt_cycles", 7'(gnt_cycles), 7'd9);
    checkOutput("full_stores", 7'(stores), 7'd4);
    checkOutput("full_done", 7'(dones), 7'd1);
    checkOutput("full_abort", 7'(aborts), 7'd0);
    applyStimulus(mk(1, 0,0,0, 0,1,4, 60,1,0));

    // Timeout: get from an empty buffer aborts on the 16th stalled cycle.
    applyStimulus(mk(1, 1,0,5, 0,0,0, 0,1,0));
    abort_at = -1; dones = 0;
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(mk(1, 1,0,5, 0,0,0, 0,1,0));
      if (obs[0] && abort_at < 0) abort_at = c;
      dones += obs[2];
    end
    checkOutput("timeout_cycle", 7'(abort_at), 7'd16);
    checkOutput("timeout_done", 7'(dones), 7'd0);
    applyStimulus(mk(1, 0,0,5, 0,0,0, 0,1,0));
    checkOutput("timeout_gnt_low", {6'd0, obs[6]}, 7'd0);

    // Oversized length is clamped to 64 beats.
    applyStimulus(mk(1, 1,1,100, 0,0,0, 10,1,0));
    stores = 0;
    for (int c = 1; c <= 64; c++) begin
      applyStimulus(mk(1, 1,1,100, 0,0,0, 10,1,0));
      stores += obs[4];
      if (c == 64) checkOutput("clamp_done_on_64", {6'd0, obs[2]}, 7'd1);
    end
    checkOutput("clamp_stores", 7'(stores), 7'd64);
    applyStimulus(mk(1, 0,1,100, 0,0,0, 10,1,0));
    checkOutput("clamp_idle_after", obs, 7'd0);

    // Request dropped mid-grant is an abort.
    applyStimulus(mk(1, 1,0,6, 0,0,0, 10,1,0));
    applyStimulus(mk(1, 1,0,6, 0,0,0, 10,1,0));
    applyStimulus(mk(1, 0,0,6, 0,0,0, 10,1,0));
    checkOutput("drop_abort", obs, 7'b1000001);

    // Reset mid-transfer: nothing asserted, no pulses.
    applyStimulus(mk(1, 0,0,0, 1,0,10, 10,1,0));
    applyStimulus(mk(1, 0,0,0, 1,0,10, 10,1,0));
    applyStimulus(mk(1, 0,0,0, 1,0,10, 10,1,0));
    applyStimulus(mk(0, 0,0,0, 1,0,10, 10,1,0));
    checkOutput("reset_mid_during", obs, 7'd0);
    applyStimulus(mk(1, 0,0,0, 0,0,10, 10,1,0));
    checkOutput("reset_mid_after", obs, 7'd0);

    // Randomized traffic checked cycle by cycle against the model.
    a_req = 1'b0; u_req = 1'b0;
    s = mk(1, 0,0,0, 0,0,0, 0,1,0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(9) == 0) a_req = ~a_req;
      if ($urandom_range(9) == 0) u_req = ~u_req;
      s.ahb_req = a_req;
      s.usb_req = u_req;
      if ($urandom_range(7) == 0) s.ahb_len = 7'(len_pick[$urandom_range(9)]);
      if ($urandom_range(7) == 0) s.usb_len = 7'(len_pick[$urandom_range(9)]);
      if ($urandom_range(15) == 0) s.ahb_wr = ~s.ahb_wr;
      if ($urandom_range(15) == 0) s.usb_wr = ~s.usb_wr;
      case ($urandom_range(3))
        0: s.occ = 7'd0;
        1: s.occ = 7'd64;
        default: s.occ = 7'($urandom_range(64));
      endcase
      s.ready = ($urandom_range(4) != 0);
      s.clr   = ($urandom_range(40) == 0);
      s.n_rst = ($urandom_range(150) != 0);
      applyStimulus(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_buffer_arbiter.md
DATA_BUFFER_ARBITER -- requirements
Module: data_buffer_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset (ports clk and n_rst); reset is sampled on the rising edge of clk only.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 n_rst  in  1  synchronous active-low reset.
REQ-004 ahb_req  in  1  AHB-side transfer request, level, held until ahb_done or xfer_abort.
REQ-005 ahb_wr  in  1  AHB direction: 1 = store into buffer, 0 = get from buffer.
REQ-006 ahb_len  in  7  AHB beat count.
REQ-007 usb_req  in  1  USB-side transfer request, level, held until usb_done or xfer_abort.
REQ-008 usb_wr  in  1  USB direction: 1 = store, 0 = get.
REQ-009 usb_len  in  7  USB beat count.
REQ-010 buffer_occupancy  in  7  current buffer fill, 0..64.
REQ-011 buf_ready  in  1  buffer can accept a beat this cycle.
REQ-012 clear  in  1  synchronous abort and flush request.
REQ-013 ahb_gnt / usb_gnt  out  1 each  ownership of the buffer port.
REQ-014 buf_store / buf_get  out  1 each  single-cycle beat strobes to the buffer.
REQ-015 ahb_done / usb_done  out  1 each  single-cycle completion pulse.
REQ-016 xfer_abort  out  1  single-cycle pulse when a grant ends without completing.

Function
REQ-017 The state machine SHALL have exactly these states: IDLE, OWN_AHB, OWN_USB.
REQ-018 Arbitration:
- Arbitration SHALL occur only in IDLE.
- If exactly one requester is asserted, that requester SHALL be granted.
- If both are asserted, the requester not granted last SHALL win; last_owner is cleared to USB, so AHB wins the first tie.
REQ-019 Grant timing:
- The grant output SHALL assert in the cycle after the request is sampled in IDLE.
- The grant SHALL stay high for every cycle spent in OWN_x.
- The grant SHALL be low in IDLE.
REQ-020 Length latch:
- On entering OWN_x, a 7-bit remaining counter SHALL load the owner's len.
- Values above 64 SHALL be clamped to 64.
- A request with len = 0 SHALL NOT be granted; it SHALL be ignored in arbitration.
REQ-021 Beat condition:
- In OWN_x, a beat SHALL issue in any cycle where buf_ready = 1 and the direction guard passes.
- Store guard: buffer_occupancy < 64. Get guard: buffer_occupancy > 0.
- A beat SHALL strobe buf_store (wr = 1) or buf_get (wr = 0) combinationally in the same cycle, and SHALL decrement remaining.
REQ-022 buf_store and buf_get SHALL never be high together, and SHALL never be high outside OWN_x.
REQ-023 Completion:
- The beat that takes remaining from 1 to 0 SHALL raise x_done in that same cycle.
- The FSM SHALL return to IDLE on the next edge.
- Minimum gap between consecutive grants is one IDLE cycle.
REQ-024 Stall timeout:
- A 4-bit stall counter SHALL count consecutive OWN_x cycles with no beat, and SHALL reset to 0 on every beat and on every state entry.
- When the counter reaches 15 with no beat in that cycle (the 16th stalled cycle), the block SHALL pulse xfer_abort, suppress done, and return to IDLE.
REQ-025 Clear:
- clear = 1 in OWN_x SHALL suppress any beat that cycle, pulse xfer_abort, and go to IDLE on the next edge.
- clear = 1 in IDLE SHALL block arbitration that cycle with no abort pulse.
- clear SHALL take priority over completion and timeout in the same cycle.
REQ-026 A request that drops while its grant is held SHALL be treated as clear: abort and return to IDLE.
REQ-027 last_owner SHALL update on every exit from OWN_x, whether by completion or by abort.

Reset
REQ-028 While n_rst = 0 at a clock edge, the block SHALL reset as follows:
- state = IDLE.
- remaining = 0, stall counter = 0, last_owner = USB.
- All outputs = 0.
REQ-029 A reset asserted mid-transfer SHALL drop the grant and strobes on the following edge, with no done or abort pulse.

Verification
REQ-030 Tie-break: ahb_req = usb_req = 1, ahb_len = 2, usb_len = 3, buf_ready = 1, occupancy = 10, both wr = 0, held -> expected sequence:
- AHB granted first, 2 buf_get, then ahb_done.
- 1 IDLE cycle.
- USB granted, 3 buf_get, then usb_done.
REQ-031 Full guard: usb_wr = 1, usb_len = 4, occupancy = 64 for 5 cycles then 60 -> expected response:
- usb_gnt is high throughout.
- No buf_store while occupancy = 64.
- Then 4 strobes and usb_done; no abort.
REQ-032 Timeout: ahb_wr = 0, ahb_len = 5, occupancy = 0 held -> xfer_abort pulses on the 16th stalled cycle, ahb_gnt drops on the next edge, and ahb_done never asserts.
REQ-033 Clear on last beat: usb_len = 1 and clear = 1 in the first OWN_USB cycle -> no strobe, no usb_done, one xfer_abort, then IDLE.
REQ-034 Edge cases: len = 0 request never granted; len = 100 yields exactly 64 beats; reset mid-transfer gives all outputs 0 on the next edge with no pulses.
